// File: rtl/axis_pkg.sv
// Shared defaults and helpers for the addressed AXI-stream demux and its per-channel FIFOs.
package axis_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 4;

    typedef logic [DATA_WIDTH-1:0] data_t;

    // Level counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_chan_fifo.sv
// Single-channel synchronous FIFO with occupancy counter; storage is not reset.
module axis_chan_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [CNT_W-1:0]      level_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      level_q, level_d;
    logic                  wr, rd;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == CNT_W'(DEPTH));
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign wr = wr_en_i & ~full_o;
    assign rd = rd_en_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr, rd})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/axi_stream_demux_fifo.sv
// Routes one addressed stream word per cycle into one of ADDR_NUM per-channel FIFOs.
module axi_stream_demux_fifo #(
    parameter int DATA_WIDTH = axis_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = axis_pkg::ADDR_WIDTH,
    parameter int ADDR_NUM   = 1 << ADDR_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = axis_pkg::cnt_w(DEPTH)
) (
    input  logic                                aclk_i,
    input  logic                                areset_i,
    input  logic [DATA_WIDTH-1:0]               tdata_i,
    input  logic [ADDR_WIDTH-1:0]               taddr_i,
    input  logic                                tvalid_i,
    output logic                                tready_o,
    output logic [ADDR_NUM-1:0][DATA_WIDTH-1:0] tdata_o,
    output logic [ADDR_NUM-1:0]                 tvalid_o,
    input  logic [ADDR_NUM-1:0]                 tready_i,
    output logic [ADDR_NUM-1:0][CNT_W-1:0]      level_o
);
    import axis_pkg::*;

    logic [ADDR_NUM-1:0] full, empty, wr_en;

    // No full-bypass: a read on a full channel frees space only from the next cycle.
    assign tready_o = ~full[taddr_i];
    assign tvalid_o = ~empty;

    always_comb begin
        wr_en = '0;
        if (tvalid_i && tready_o) wr_en[taddr_i] = 1'b1;
    end

    for (genvar k = 0; k < ADDR_NUM; k++) begin : g_chan
        axis_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .CNT_W      (CNT_W)
        ) u_fifo (
            .clk_i   (aclk_i),
            .rst_i   (areset_i),
            .wr_en_i (wr_en[k]),
            .din_i   (tdata_i),
            .rd_en_i (tready_i[k]),
            .dout_o  (tdata_o[k]),
            .empty_o (empty[k]),
            .full_o  (full[k]),
            .level_o (level_o[k])
        );
    end

endmodule

// File: tb/tb_axi_stream_demux_fifo.sv
// Directed bench for axi_stream_demux_fifo with 4 channels of depth 4.
module tb_axi_stream_demux_fifo;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int AN = 4;
    localparam int DP = 4;
    localparam int CW = 3;

    logic                    aclk_i = 1'b0;
    logic                    areset_i;
    logic [DW-1:0]           tdata_i;
    logic [AW-1:0]           taddr_i;
    logic                    tvalid_i;
    logic                    tready_o;
    logic [AN-1:0][DW-1:0]   tdata_o;
    logic [AN-1:0]           tvalid_o;
    logic [AN-1:0]           tready_i;
    logic [AN-1:0][CW-1:0]   level_o;

    int n_tests = 0;
    int n_fail  = 0;

    axi_stream_demux_fifo #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .ADDR_NUM (AN), .DEPTH (DP), .CNT_W (CW)
    ) dut (
        .aclk_i   (aclk_i),
        .areset_i (areset_i),
        .tdata_i  (tdata_i),
        .taddr_i  (taddr_i),
        .tvalid_i (tvalid_i),
        .tready_o (tready_o),
        .tdata_o  (tdata_o),
        .tvalid_o (tvalid_o),
        .tready_i (tready_i),
        .level_o  (level_o)
    );

    always #5 aclk_i = ~aclk_i;

    task automatic tick();
        @(posedge aclk_i);
        #1;
    endtask

    task automatic test_reset();
        areset_i = 1'b1; tvalid_i = 1'b0; tdata_i = '0; taddr_i = '0; tready_i = '0;
        tick(); tick();
        areset_i = 1'b0;
        #1;
        n_tests++;
        if (tvalid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_tvalid got %b want 0000", tvalid_o); end
        n_tests++;
        if (level_o !== '0) begin n_fail++; $display("FAIL reset_level got %h want 0", level_o); end
        n_tests++;
        if (tready_o !== 1'b1) begin n_fail++; $display("FAIL reset_tready got %b want 1", tready_o); end
    endtask

    task automatic test_single_route();
        tvalid_i = 1'b1; tdata_i = 16'hA5A5; taddr_i = 2'd2; tready_i = 4'b0000;
        tick();
        tvalid_i = 1'b0;
        #1;
        n_tests++;
        if (tvalid_o !== 4'b0100) begin n_fail++; $display("FAIL route_tvalid got %b want 0100", tvalid_o); end
        n_tests++;
        if (tdata_o[2] !== 16'hA5A5) begin n_fail++; $display("FAIL route_data got %h want a5a5", tdata_o[2]); end
        n_tests++;
        if (level_o[2] !== 3'd1) begin n_fail++; $display("FAIL route_level got %0d want 1", level_o[2]); end
        tready_i = 4'b0100;
        tick();
        tready_i = 4'b0000;
        #1;
        n_tests++;
        if (tvalid_o !== 4'b0000) begin n_fail++; $display("FAIL route_drain_tvalid got %b want 0000", tvalid_o); end
        n_tests++;
        if (level_o[2] !== 3'd0) begin n_fail++; $display("FAIL route_drain_level got %0d want 0", level_o[2]); end
    endtask

    task automatic test_fill_backpressure();
        tready_i = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            tvalid_i = 1'b1; taddr_i = 2'd1; tdata_i = 16'(i);
            #1;
            n_tests++;
            if (tready_o !== (i <= 4)) begin n_fail++; $display("FAIL fill_tready word %0d got %b want %b", i, tready_o, (i <= 4)); end
            tick();
        end
        n_tests++;
        if (level_o[1] !== 3'd4) begin n_fail++; $display("FAIL fill_level got %0d want 4", level_o[1]); end
        n_tests++;
        if (tdata_o[1] !== 16'h0001) begin n_fail++; $display("FAIL fill_head got %h want 0001", tdata_o[1]); end
        taddr_i = 2'd3; tdata_i = 16'h0005;
        #1;
        n_tests++;
        if (tready_o !== 1'b1) begin n_fail++; $display("FAIL other_chan_tready got %b want 1", tready_o); end
        tick();
        tvalid_i = 1'b0;
        #1;
        n_tests++;
        if (level_o[3] !== 3'd1 || tdata_o[3] !== 16'h0005) begin
            n_fail++; $display("FAIL other_chan_accept got level %0d data %h want 1 0005", level_o[3], tdata_o[3]);
        end
    endtask

    task automatic test_full_read();
        logic [DW-1:0] exp_q [4];
        exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'h0006};
        tvalid_i = 1'b1; taddr_i = 2'd1; tdata_i = 16'h0006; tready_i = 4'b0010;
        #1;
        n_tests++;
        if (tready_o !== 1'b0) begin n_fail++; $display("FAIL full_read_tready got %b want 0", tready_o); end
        tick();
        tready_i = 4'b0000;
        #1;
        n_tests++;
        if (level_o[1] !== 3'd3 || tdata_o[1] !== 16'h0002) begin
            n_fail++; $display("FAIL full_read_level got level %0d head %h want 3 0002", level_o[1], tdata_o[1]);
        end
        n_tests++;
        if (tready_o !== 1'b1) begin n_fail++; $display("FAIL after_read_tready got %b want 1", tready_o); end
        tick();
        tvalid_i = 1'b0;
        #1;
        n_tests++;
        if (level_o[1] !== 3'd4) begin n_fail++; $display("FAIL after_read_level got %0d want 4", level_o[1]); end
        tready_i = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (tvalid_o[1] !== 1'b1 || tdata_o[1] !== exp_q[i]) begin
                n_fail++; $display("FAIL drain_order idx %0d got v%b %h want v1 %h", i, tvalid_o[1], tdata_o[1], exp_q[i]);
            end
            tick();
        end
        tready_i = 4'b0000;
        #1;
        n_tests++;
        if (tvalid_o !== 4'b0000 || level_o !== '0) begin
            n_fail++; $display("FAIL drain_empty got tvalid %b level %h want 0000 0", tvalid_o, level_o);
        end
    endtask

    task automatic test_back_to_back_wrap();
        tready_i = 4'b0001; taddr_i = 2'd0; tvalid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tdata_i = 16'h0010 + 16'(i);
            #1;
            n_tests++;
            if (tready_o !== 1'b1) begin n_fail++; $display("FAIL wrap_tready word %0d got %b want 1", i, tready_o); end
            tick();
            n_tests++;
            if (tvalid_o[0] !== 1'b1 || tdata_o[0] !== 16'h0010 + 16'(i) || level_o[0] !== 3'd1) begin
                n_fail++; $display("FAIL wrap_stream word %0d got v%b %h lvl %0d want v1 %h lvl 1",
                                   i, tvalid_o[0], tdata_o[0], level_o[0], 16'h0010 + 16'(i));
            end
        end
        tvalid_i = 1'b0;
        tick();
        tready_i = 4'b0000;
        n_tests++;
        if (tvalid_o[0] !== 1'b0 || level_o[0] !== 3'd0) begin
            n_fail++; $display("FAIL wrap_final got v%b lvl %0d want v0 lvl 0", tvalid_o[0], level_o[0]);
        end
    endtask

    task automatic test_reset_mid_traffic();
        logic [AW-1:0] addrs [4];
        addrs = '{2'd0, 2'd0, 2'd3, 2'd3};
        tready_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tvalid_i = 1'b1; taddr_i = addrs[i]; tdata_i = 16'h0100 + 16'(i);
            tick();
        end
        tvalid_i = 1'b0;
        #1;
        n_tests++;
        if (level_o[0] !== 3'd2 || level_o[3] !== 3'd2) begin
            n_fail++; $display("FAIL pre_reset_level got %0d %0d want 2 2", level_o[0], level_o[3]);
        end
        // Reads and a write are all presented in the reset cycle; none may take effect.
        areset_i = 1'b1; tready_i = 4'b1111; tvalid_i = 1'b1; taddr_i = 2'd0; tdata_i = 16'hDEAD;
        tick();
        areset_i = 1'b0; tready_i = 4'b0000; tvalid_i = 1'b0;
        #1;
        n_tests++;
        if (tvalid_o !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_tvalid got %b want 0000", tvalid_o); end
        n_tests++;
        if (level_o !== '0) begin n_fail++; $display("FAIL mid_reset_level got %h want 0", level_o); end
        n_tests++;
        if (tready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_tready got %b want 1", tready_o); end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_fill_backpressure();
        test_full_read();
        test_back_to_back_wrap();
        test_reset_mid_traffic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
